eth_frame_tx_64: RTL and testbench

- Downstream neighbour of the 64-bit IP-to-Ethernet transmit stage.
- Consumes a parallel Ethernet header (dest MAC, src MAC, ethertype) plus a 64-bit AXI-Stream payload.
- Emits one flat 64-bit AXI-Stream frame with the 14-byte header prepended and the payload realigned by 6 byte lanes.
- Feeds the MAC transmit path.

---
 rtl/eth_frame_tx_64.sv | 247 ++++++++++++++++++++++++
 tb/tb_eth_frame_tx_64.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_tx_64.sv
// eth_frame_tx_64
//
// Purpose: prepends a 14-byte Ethernet header (dest MAC, src MAC, ethertype)
// to a 64-bit AXI-Stream payload and emits one flat 64-bit frame stream.
// The payload is shifted up by 6 byte lanes, so that the last two lanes of each
// output word carry the first two bytes of the next payload word.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_eth_hdr_*                   header handshake and fields
//   s_eth_payload_axis_*          payload stream in (lane 0 first on the wire)
//   m_axis_*                      frame stream out
//   busy                          high from header accept to last output transfer
//
// States:
//   IDLE          | waiting for a header; Word0 is issued on header accept
//   WRITE_HEADER  | Word0 issued; the first payload word forms Word1
//   WRITE_PAYLOAD | each payload word emits {bytes 0-1, carry of bytes 2-7}
//   WRITE_LAST    | flush the carried bytes of the final payload word

module eth_frame_tx_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,

    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_eth_payload_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE_HEADER,
        WRITE_PAYLOAD,
        WRITE_LAST
    } state_t;

    // Packed output-stage word: {user, last, keep, data}
    localparam int SW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    state_t                state_q, state_d;
    logic                  hdr_ready_q, hdr_ready_d;
    logic                  pay_ready_q, pay_ready_d;
    logic                  busy_q, busy_d;
    logic [31:0]           src_lo_q, src_lo_d;
    logic [15:0]           type_q, type_d;
    logic [47:0]           carry_q, carry_d;
    logic [KEEP_WIDTH-1:0] last_keep_q, last_keep_d;
    logic [USER_WIDTH-1:0] last_user_q, last_user_d;

    logic [SW-1:0]         out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [SW-1:0]         skid_q, skid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  ready_int_q, ready_int_d;

    logic [DATA_WIDTH-1:0] int_tdata;
    logic [KEEP_WIDTH-1:0] int_tkeep;
    logic                  int_tvalid;
    logic                  int_tlast;
    logic [USER_WIDTH-1:0] int_tuser;
    logic [SW-1:0]         int_word;

    logic                  hdr_accept;
    logic                  pay_accept;

    assign hdr_accept = s_eth_hdr_valid & hdr_ready_q;
    assign pay_accept = s_eth_payload_axis_tvalid & pay_ready_q;

    // Framing FSM
    always_comb begin
        state_d     = state_q;
        src_lo_d    = src_lo_q;
        type_d      = type_q;
        carry_d     = carry_q;
        last_keep_d = last_keep_q;
        last_user_d = last_user_q;
        int_tdata   = '0;
        int_tkeep   = '0;
        int_tvalid  = 1'b0;
        int_tlast   = 1'b0;
        int_tuser   = '0;

        case (state_q)
            IDLE: begin
                if (hdr_accept) begin
                    // Word0 goes straight from the header inputs so it is
                    // valid the cycle after the header handshake.
                    src_lo_d   = s_eth_src_mac[31:0];
                    type_d     = s_eth_type;
                    int_tdata  = {s_eth_src_mac[39:32], s_eth_src_mac[47:40],
                                  s_eth_dest_mac[7:0],  s_eth_dest_mac[15:8],
                                  s_eth_dest_mac[23:16], s_eth_dest_mac[31:24],
                                  s_eth_dest_mac[39:32], s_eth_dest_mac[47:40]};
                    int_tkeep  = '1;
                    int_tvalid = 1'b1;
                    state_d    = WRITE_HEADER;
                end
            end

            WRITE_HEADER, WRITE_PAYLOAD: begin
                if (pay_accept) begin
                    carry_d    = s_eth_payload_axis_tdata[63:16];
                    int_tvalid = 1'b1;
                    int_tkeep  = '1;
                    if (state_q == WRITE_HEADER)
                        int_tdata = {s_eth_payload_axis_tdata[15:0],
                                     type_q[7:0], type_q[15:8],
                                     src_lo_q[7:0], src_lo_q[15:8],
                                     src_lo_q[23:16], src_lo_q[31:24]};
                    else
                        int_tdata = {s_eth_payload_axis_tdata[15:0], carry_q};
                    state_d = WRITE_PAYLOAD;

                    if (s_eth_payload_axis_tlast) begin
                        // tkeep is contiguous from lane 0, so lane 2 set
                        // means more than two bytes: the remainder spills
                        // into one extra word whose keep is tkeep >> 2.
                        if (s_eth_payload_axis_tkeep[2]) begin
                            last_keep_d = {2'b00, s_eth_payload_axis_tkeep[7:2]};
                            last_user_d = s_eth_payload_axis_tuser;
                            state_d     = WRITE_LAST;
                        end else begin
                            int_tkeep = {s_eth_payload_axis_tkeep[1:0], 6'h3F};
                            int_tlast = 1'b1;
                            int_tuser = s_eth_payload_axis_tuser;
                            state_d   = IDLE;
                        end
                    end
                end
            end

            WRITE_LAST: begin
                if (ready_int_q) begin
                    int_tdata  = {16'h0000, carry_q};
                    int_tkeep  = last_keep_q;
                    int_tvalid = 1'b1;
                    int_tlast  = 1'b1;
                    int_tuser  = last_user_q;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Output register plus one-word skid buffer. ready_int is registered, so
    // the FSM may issue one word after the consumer stalls; the skid absorbs it.
    always_comb begin
        int_word     = {int_tuser, int_tlast, int_tkeep, int_tdata};
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        ready_int_d  = m_axis_tready | (~skid_valid_q & (~out_valid_q | ~int_tvalid));

        if (ready_int_q) begin
            if (m_axis_tready || !out_valid_q) begin
                out_valid_d = int_tvalid;
                out_d       = int_word;
            end else begin
                skid_valid_d = int_tvalid;
                skid_d       = int_word;
            end
        end else if (m_axis_tready) begin
            out_valid_d  = skid_valid_q;
            out_d        = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        hdr_ready_d = (state_d == IDLE) & ready_int_d;
        pay_ready_d = ((state_d == WRITE_HEADER) | (state_d == WRITE_PAYLOAD)) & ready_int_d;
        busy_d      = busy_q;
        if (hdr_accept)
            busy_d = 1'b1;
        else if (out_valid_q && m_axis_tready && m_axis_tlast)
            busy_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_ready_q  <= 1'b0;
            pay_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            src_lo_q     <= '0;
            type_q       <= '0;
            carry_q      <= '0;
            last_keep_q  <= '0;
            last_user_q  <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_int_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_ready_q  <= hdr_ready_d;
            pay_ready_q  <= pay_ready_d;
            busy_q       <= busy_d;
            src_lo_q     <= src_lo_d;
            type_q       <= type_d;
            carry_q      <= carry_d;
            last_keep_q  <= last_keep_d;
            last_user_q  <= last_user_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_int_q  <= ready_int_d;
        end
    end

    assign s_eth_hdr_ready           = hdr_ready_q;
    assign s_eth_payload_axis_tready = pay_ready_q;
    assign busy                      = busy_q;
    assign m_axis_tvalid             = out_valid_q;
    assign m_axis_tdata              = out_q[DATA_WIDTH-1:0];
    assign m_axis_tkeep              = out_q[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast              = out_q[DATA_WIDTH+KEEP_WIDTH];
    assign m_axis_tuser              = out_q[SW-1 -: USER_WIDTH];

endmodule

// File: tb/tb_eth_frame_tx_64.sv
module tb_eth_frame_tx_64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_eth_hdr_valid = 1'b0;
    logic        s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac = '0;
    logic [47:0] s_eth_src_mac = '0;
    logic [15:0] s_eth_type = '0;
    logic [63:0] s_eth_payload_axis_tdata = '0;
    logic [7:0]  s_eth_payload_axis_tkeep = '0;
    logic        s_eth_payload_axis_tvalid = 1'b0;
    logic        s_eth_payload_axis_tready;
    logic        s_eth_payload_axis_tlast = 1'b0;
    logic [0:0]  s_eth_payload_axis_tuser = '0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        busy;

    eth_frame_tx_64 dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tkeep  (s_eth_payload_axis_tkeep),
        .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
        .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
        .m_axis_tdata              (m_axis_tdata),
        .m_axis_tkeep              (m_axis_tkeep),
        .m_axis_tvalid             (m_axis_tvalid),
        .m_axis_tready             (m_axis_tready),
        .m_axis_tlast              (m_axis_tlast),
        .m_axis_tuser              (m_axis_tuser),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [47:0] hdr_dest;
    logic [47:0] hdr_src;
    logic [15:0] hdr_type;
    logic [7:0]  pay_base;

    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];
    logic        q_user[$];
    int          q_cyc[$];
    int          hdr_acc_cyc;
    int          first_valid_cyc;
    logic        busy_at_last;
    logic        timed_out;

    // ---------------- reference model: flat byte stream ----------------
    function automatic logic [7:0] stream_byte(int b);
        if (b < 6)       return hdr_dest[47-8*b -: 8];
        else if (b < 12) return hdr_src[47-8*(b-6) -: 8];
        else if (b < 14) return hdr_type[15-8*(b-12) -: 8];
        else             return pay_base + 8'(b-14);
    endfunction

    function automatic logic [7:0] exp_keep(int w, int nbytes);
        int rem = 14 + nbytes - 8*w;
        if (rem >= 8) return 8'hFF;
        if (rem <= 0) return 8'h00;
        return 8'((1 << rem) - 1);
    endfunction

    function automatic logic [63:0] exp_data(int w, int nbytes);
        logic [63:0] d = '0;
        for (int i = 0; i < 8; i++)
            if (8*w + i < 14 + nbytes) d[8*i +: 8] = stream_byte(8*w + i);
        return d;
    endfunction

    function automatic logic [63:0] keep_mask(logic [7:0] k);
        logic [63:0] m = '0;
        for (int i = 0; i < 8; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [63:0] pay_word(int j, int nbytes);
        logic [63:0] d = '0;
        for (int i = 0; i < 8; i++)
            if (8*j + i < nbytes) d[8*i +: 8] = pay_base + 8'(8*j + i);
        return d;
    endfunction

    function automatic logic [7:0] pay_keep(int j, int nbytes);
        logic [7:0] k = '0;
        for (int i = 0; i < 8; i++) if (8*j + i < nbytes) k[i] = 1'b1;
        return k;
    endfunction

    task automatic clear_inputs();
        s_eth_hdr_valid           = 1'b0;
        s_eth_payload_axis_tvalid = 1'b0;
        s_eth_payload_axis_tdata  = '0;
        s_eth_payload_axis_tkeep  = '0;
        s_eth_payload_axis_tlast  = 1'b0;
        s_eth_payload_axis_tuser  = '0;
    endtask

    // Drives one header plus payload and records every output transfer.
    task automatic run_frame(input int nbytes, input logic user_last,
                             input bit toggle, input int abort_at);
        int pidx = 0;
        int nin = (nbytes + 7) / 8;
        int cyc = 0;
        bit hdr_done = 0;
        bit seen_valid = 0;
        bit done = 0;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_user.delete(); q_cyc.delete();
        hdr_acc_cyc = -1; first_valid_cyc = -1; timed_out = 1'b0; busy_at_last = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            s_eth_hdr_valid = !hdr_done;
            s_eth_dest_mac  = hdr_dest;
            s_eth_src_mac   = hdr_src;
            s_eth_type      = hdr_type;
            m_axis_tready   = toggle ? (cyc % 2 == 0) : 1'b1;
            if (pidx < nin) begin
                s_eth_payload_axis_tvalid = 1'b1;
                s_eth_payload_axis_tdata  = pay_word(pidx, nbytes);
                s_eth_payload_axis_tkeep  = pay_keep(pidx, nbytes);
                s_eth_payload_axis_tlast  = (pidx == nin - 1);
                s_eth_payload_axis_tuser  = (pidx == nin - 1) ? user_last : 1'b0;
            end else begin
                s_eth_payload_axis_tvalid = 1'b0;
                s_eth_payload_axis_tdata  = '0;
                s_eth_payload_axis_tkeep  = '0;
                s_eth_payload_axis_tlast  = 1'b0;
                s_eth_payload_axis_tuser  = '0;
            end
            #1;
            if (hdr_done && !seen_valid && m_axis_tvalid) begin
                seen_valid = 1;
                first_valid_cyc = cyc_cnt;
            end
            if (s_eth_hdr_valid && s_eth_hdr_ready) begin
                hdr_done = 1;
                hdr_acc_cyc = cyc_cnt;
            end
            if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tready) pidx++;
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_keep.push_back(m_axis_tkeep);
                q_last.push_back(m_axis_tlast);
                q_user.push_back(m_axis_tuser[0]);
                q_cyc.push_back(cyc_cnt);
                if (m_axis_tlast) begin
                    done = 1;
                    busy_at_last = busy;
                end
                if (abort_at >= 0 && q_data.size() == abort_at) done = 1;
            end
            cyc++;
        end
        if (!done) timed_out = 1'b1;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b1;
        s_eth_payload_axis_tvalid = 1'b0;
        #1;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy} !== 4'b0000)
            $display("FAIL reset_ctrl got %b exp 0000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy});
        else n_pass++;
        n_checks++;
        if ({m_axis_tdata, m_axis_tkeep} !== 72'h0)
            $display("FAIL reset_data got %h exp 0", {m_axis_tdata, m_axis_tkeep});
        else n_pass++;
        n_checks++;
        if ({s_eth_hdr_ready, s_eth_payload_axis_tready} !== 2'b00)
            $display("FAIL reset_ready got %b exp 00", {s_eth_hdr_ready, s_eth_payload_axis_tready});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_eth_hdr_ready !== 1'b0) $display("FAIL hdr_ready_at_release got %b exp 0", s_eth_hdr_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (s_eth_hdr_ready !== 1'b1) $display("FAIL hdr_ready_after_clk got %b exp 1", s_eth_hdr_ready);
        else n_pass++;
        // Payload offered with no header must be held off.
        s_eth_payload_axis_tvalid = 1'b1;
        s_eth_payload_axis_tkeep  = 8'hFF;
        s_eth_payload_axis_tlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({s_eth_payload_axis_tready, m_axis_tvalid, busy} !== 3'b000)
                $display("FAIL payload_holdoff cyc%0d got %b exp 000", i,
                         {s_eth_payload_axis_tready, m_axis_tvalid, busy});
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_frame_basic();
        logic [63:0] lit_data [3];
        logic [7:0]  lit_keep [3];
        lit_data[0] = 64'h515A_0605_0403_02DA;
        lit_data[1] = 64'h0100_0080_5554_5352;
        lit_data[2] = 64'h0000_0706_0504_0302;
        lit_keep[0] = 8'hFF; lit_keep[1] = 8'hFF; lit_keep[2] = 8'h3F;
        hdr_dest = 48'hDA02_0304_0506;
        hdr_src  = 48'h5A51_5253_5455;
        hdr_type = 16'h8000;
        pay_base = 8'h00;
        run_frame(8, 1'b0, 1'b0, -1);
        n_checks++;
        if (timed_out !== 1'b0 || q_data.size() != 3)
            $display("FAIL basic_words got %0d timeout %b exp 3", q_data.size(), timed_out);
        else n_pass++;
        n_checks++;
        if (first_valid_cyc - hdr_acc_cyc != 1)
            $display("FAIL basic_latency got %0d exp 1", first_valid_cyc - hdr_acc_cyc);
        else n_pass++;
        for (int w = 0; w < q_data.size() && w < 3; w++) begin
            n_checks++;
            if ((q_data[w] & keep_mask(lit_keep[w])) !== lit_data[w] || q_keep[w] !== lit_keep[w] ||
                q_last[w] !== (w == 2) || q_user[w] !== 1'b0)
                $display("FAIL basic_w%0d got %h/%h/%b/%b exp %h/%h/%b/0", w, q_data[w], q_keep[w],
                         q_last[w], q_user[w], lit_data[w], lit_keep[w], (w == 2));
            else n_pass++;
        end
    endtask

    task automatic test_short_frames();
        int          nb   [2];
        logic [7:0]  kexp [2];
        nb[0] = 2; kexp[0] = 8'hFF;
        nb[1] = 1; kexp[1] = 8'h7F;
        hdr_dest = 48'h0011_2233_4455;
        hdr_src  = 48'h6677_8899_AABB;
        hdr_type = 16'h0800;
        for (int t = 0; t < 2; t++) begin
            pay_base = 8'hA0 + 8'(t);
            run_frame(nb[t], 1'b0, 1'b0, -1);
            n_checks++;
            if (timed_out !== 1'b0 || q_data.size() != 2)
                $display("FAIL short%0d_words got %0d exp 2", nb[t], q_data.size());
            else n_pass++;
            if (q_data.size() == 2) begin
                n_checks++;
                if (q_keep[1] !== kexp[t] || q_last[1] !== 1'b1 || q_last[0] !== 1'b0)
                    $display("FAIL short%0d_last got keep %h last %b%b exp %h 10", nb[t],
                             q_keep[1], q_last[1], q_last[0], kexp[t]);
                else n_pass++;
                n_checks++;
                if ((q_data[1] & keep_mask(kexp[t])) !== exp_data(1, nb[t]))
                    $display("FAIL short%0d_data got %h exp %h", nb[t], q_data[1], exp_data(1, nb[t]));
                else n_pass++;
            end
            n_checks++;
            if (busy_at_last !== 1'b1 || busy !== 1'b0)
                $display("FAIL short%0d_busy got %b then %b exp 1 then 0", nb[t], busy_at_last, busy);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ref_data[$];
        hdr_dest = 48'h0102_0304_0506;
        hdr_src  = 48'h1112_1314_1516;
        hdr_type = 16'h86DD;
        pay_base = 8'h10;
        run_frame(64, 1'b0, 1'b0, -1);
        ref_data = q_data;
        run_frame(64, 1'b0, 1'b1, -1);
        n_checks++;
        if (timed_out !== 1'b0 || q_data.size() != 10)
            $display("FAIL bp_words got %0d exp 10", q_data.size());
        else n_pass++;
        if (q_data.size() == 10) begin
            n_checks++;
            if (q_keep[9] !== 8'h3F || q_last[9] !== 1'b1)
                $display("FAIL bp_last got keep %h last %b exp 3f 1", q_keep[9], q_last[9]);
            else n_pass++;
        end
        for (int w = 0; w < q_data.size(); w++) begin
            n_checks++;
            if ((q_data[w] & keep_mask(exp_keep(w, 64))) !== exp_data(w, 64) ||
                q_keep[w] !== exp_keep(w, 64) || q_last[w] !== (w == 9))
                $display("FAIL bp_w%0d got %h/%h exp %h/%h", w, q_data[w], q_keep[w],
                         exp_data(w, 64), exp_keep(w, 64));
            else n_pass++;
            if (w < ref_data.size()) begin
                n_checks++;
                if (q_data[w] !== ref_data[w])
                    $display("FAIL bp_vs_free_w%0d got %h exp %h", w, q_data[w], ref_data[w]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_tuser();
        hdr_dest = 48'hFFFF_FFFF_FFFF;
        hdr_src  = 48'h0200_0000_0001;
        hdr_type = 16'h0806;
        pay_base = 8'h30;
        run_frame(11, 1'b1, 1'b0, -1);
        n_checks++;
        if (timed_out !== 1'b0 || q_data.size() != 4)
            $display("FAIL tuser_words got %0d exp 4", q_data.size());
        else n_pass++;
        if (q_data.size() == 4) begin
            n_checks++;
            if (q_keep[3] !== 8'h01 || q_last[3] !== 1'b1 || q_data[3][7:0] !== 8'h3A)
                $display("FAIL tuser_last got %h/%b/%h exp 01/1/3a", q_keep[3], q_last[3], q_data[3][7:0]);
            else n_pass++;
            n_checks++;
            if ({q_user[0], q_user[1], q_user[2], q_user[3]} !== 4'b0001)
                $display("FAIL tuser_words_user got %b exp 0001",
                         {q_user[0], q_user[1], q_user[2], q_user[3]});
            else n_pass++;
            n_checks++;
            if (q_data[2] !== exp_data(2, 11))
                $display("FAIL tuser_w2 got %h exp %h", q_data[2], exp_data(2, 11));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        hdr_dest = 48'h0A0B_0C0D_0E0F;
        hdr_src  = 48'h1A1B_1C1D_1E1F;
        hdr_type = 16'h1234;
        pay_base = 8'h50;
        run_frame(64, 1'b0, 1'b0, 3);
        n_checks++;
        if (timed_out !== 1'b0 || q_data.size() != 3)
            $display("FAIL midrst_progress got %0d exp 3", q_data.size());
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({m_axis_tvalid, busy, s_eth_hdr_ready, s_eth_payload_axis_tready} !== 4'b0000)
            $display("FAIL midrst_outputs got %b exp 0000",
                     {m_axis_tvalid, busy, s_eth_hdr_ready, s_eth_payload_axis_tready});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_eth_hdr_ready !== 1'b1 || m_axis_tvalid !== 1'b0)
            $display("FAIL midrst_recover got %b%b exp 10", s_eth_hdr_ready, m_axis_tvalid);
        else n_pass++;
        test_frame_basic();
    endtask

    task automatic test_back_to_back();
        int last_a;
        hdr_dest = 48'h0200_0000_00AA;
        hdr_src  = 48'h0200_0000_00BB;
        hdr_type = 16'h88B5;
        pay_base = 8'h70;
        run_frame(16, 1'b0, 1'b0, -1);
        last_a = (q_cyc.size() > 0) ? q_cyc[q_cyc.size()-1] : -100;
        pay_base = 8'h90;
        run_frame(16, 1'b0, 1'b0, -1);
        n_checks++;
        if (timed_out !== 1'b0 || q_data.size() != 4)
            $display("FAIL b2b_words got %0d exp 4", q_data.size());
        else n_pass++;
        n_checks++;
        if (q_cyc.size() == 0 || q_cyc[0] - last_a > 2)
            $display("FAIL b2b_gap got %0d exp <=2", (q_cyc.size() > 0) ? q_cyc[0] - last_a : -1);
        else n_pass++;
        for (int w = 0; w < q_data.size(); w++) begin
            n_checks++;
            if ((q_data[w] & keep_mask(exp_keep(w, 16))) !== exp_data(w, 16) ||
                q_keep[w] !== exp_keep(w, 16))
                $display("FAIL b2b_w%0d got %h/%h exp %h/%h", w, q_data[w], q_keep[w],
                         exp_data(w, 16), exp_keep(w, 16));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_short_frames();
        test_backpressure();
        test_tuser();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
